// File: rtl/mem_burst_arb.sv
// Round-robin arbiter merging two video_pro channels (4 burst requesters) onto one DDR controller port.
// Optional watchdog enabled by `define ARB_TIMEOUT_EN.
//   state | meaning
//   IDLE  | no burst in flight, arbitrate on next edge
//   BUSY  | burst for grant_q in flight, wait for matching finish
module mem_burst_arb #(
    parameter int MEM_DATA_BITS  = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     c0_wr_burst_req,
    input  logic [9:0]               c0_wr_burst_len,
    input  logic [23:0]              c0_wr_burst_addr,
    input  logic [MEM_DATA_BITS-1:0] c0_wr_burst_data,
    output logic                     c0_wr_burst_data_req,
    output logic                     c0_wr_burst_finish,
    input  logic                     c0_rd_burst_req,
    input  logic [9:0]               c0_rd_burst_len,
    input  logic [23:0]              c0_rd_burst_addr,
    output logic                     c0_rd_burst_data_valid,
    output logic                     c0_rd_burst_finish,
    output logic [MEM_DATA_BITS-1:0] c0_rd_burst_data,
    input  logic                     c1_wr_burst_req,
    input  logic [9:0]               c1_wr_burst_len,
    input  logic [23:0]              c1_wr_burst_addr,
    input  logic [MEM_DATA_BITS-1:0] c1_wr_burst_data,
    output logic                     c1_wr_burst_data_req,
    output logic                     c1_wr_burst_finish,
    input  logic                     c1_rd_burst_req,
    input  logic [9:0]               c1_rd_burst_len,
    input  logic [23:0]              c1_rd_burst_addr,
    output logic                     c1_rd_burst_data_valid,
    output logic                     c1_rd_burst_finish,
    output logic [MEM_DATA_BITS-1:0] c1_rd_burst_data,
    output logic                     wr_burst_req,
    output logic [9:0]               wr_burst_len,
    output logic [23:0]              wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     wr_burst_data_req,
    input  logic                     wr_burst_finish,
    output logic                     rd_burst_req,
    output logic [9:0]               rd_burst_len,
    output logic [23:0]              rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     rd_burst_finish,
    output logic                     arb_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] req_vec;
    logic [3:0] sel;
    logic [1:0] cand;
    logic [1:0] pick_idx;
    logic       pick_found;
    logic       busy, gnt_wr, gnt_rd, gnt_req;
    logic       fin_ok, timeout_hit, done;

    assign req_vec = {c1_rd_burst_req, c1_wr_burst_req, c0_rd_burst_req, c0_wr_burst_req};
    // outputs are forced low during the reset cycle even if a burst was in flight
    assign busy    = (state_q == BUSY) && !rst;
    assign gnt_wr  = busy && !grant_q[0];
    assign gnt_rd  = busy &&  grant_q[0];
    assign gnt_req = req_vec[grant_q];
    assign fin_ok  = (gnt_wr && wr_burst_finish) || (gnt_rd && rd_burst_finish);
    assign done    = fin_ok || timeout_hit;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!pick_found && req_vec[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    grant_d = pick_idx;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 2'd0;
            rr_ptr_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] timer_q, timer_d;
    logic        arb_err_q, arb_err_d;

    assign timeout_hit = busy && (timer_q == 16'(TIMEOUT_CYCLES - 1)) && !fin_ok;

    always_comb begin
        timer_d   = (state_q == BUSY) ? timer_q + 16'd1 : 16'd0;
        arb_err_d = arb_err_q || timeout_hit;
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            timer_q   <= 16'd0;
            arb_err_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            arb_err_q <= arb_err_d;
        end
    end

    assign arb_err = arb_err_q && !rst;
`else
    assign timeout_hit = 1'b0;
    assign arb_err     = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) sel[i] = busy && (grant_q == 2'(i));
    end

    assign wr_burst_req  = gnt_wr && gnt_req;
    assign wr_burst_len  = gnt_wr ? (grant_q[1] ? c1_wr_burst_len  : c0_wr_burst_len)  : '0;
    assign wr_burst_addr = gnt_wr ? (grant_q[1] ? c1_wr_burst_addr : c0_wr_burst_addr) : '0;
    assign wr_burst_data = gnt_wr ? (grant_q[1] ? c1_wr_burst_data : c0_wr_burst_data) : '0;
    assign rd_burst_req  = gnt_rd && gnt_req;
    assign rd_burst_len  = gnt_rd ? (grant_q[1] ? c1_rd_burst_len  : c0_rd_burst_len)  : '0;
    assign rd_burst_addr = gnt_rd ? (grant_q[1] ? c1_rd_burst_addr : c0_rd_burst_addr) : '0;

    // a watchdog expiry reuses the client finish so the requester releases
    assign c0_wr_burst_data_req   = sel[0] && wr_burst_data_req;
    assign c0_wr_burst_finish     = sel[0] && (wr_burst_finish || timeout_hit);
    assign c0_rd_burst_data_valid = sel[1] && rd_burst_data_valid;
    assign c0_rd_burst_finish     = sel[1] && (rd_burst_finish || timeout_hit);
    assign c1_wr_burst_data_req   = sel[2] && wr_burst_data_req;
    assign c1_wr_burst_finish     = sel[2] && (wr_burst_finish || timeout_hit);
    assign c1_rd_burst_data_valid = sel[3] && rd_burst_data_valid;
    assign c1_rd_burst_finish     = sel[3] && (rd_burst_finish || timeout_hit);
    assign c0_rd_burst_data       = rd_burst_data;
    assign c1_rd_burst_data       = rd_burst_data;

endmodule
